// File: rtl/aes_batch_loader.sv
// Packs a 32-bit word stream into up to LANES 128-bit plaintext blocks and holds the
// batch under valid/ready. Optional AES_LOADER_BSWAP_EN byte-reverses each input word.
module aes_batch_loader #(
    parameter int LANES         = 5,
    parameter int FLUSH_TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [31:0]            s_data,
    input  logic                   s_valid,
    input  logic                   s_last,
    output logic                   s_ready,
    output logic [128*LANES-1:0]   batch_in,
    output logic [LANES-1:0]       batch_en,
    output logic                   batch_valid,
    input  logic                   batch_ready
);

    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int IDLE_W = (FLUSH_TIMEOUT > 1) ? $clog2(FLUSH_TIMEOUT) : 1;
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(LANES - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'((FLUSH_TIMEOUT > 0) ? FLUSH_TIMEOUT - 1 : 0);
    localparam logic              FLUSH_EN  = (FLUSH_TIMEOUT != 0);

    typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

    state_t                 state_q;
    logic [1:0]             word_q;
    logic [LANE_W-1:0]      lane_q;
    logic [IDLE_W-1:0]      idle_q;
    logic [128*LANES-1:0]   batch_q;
    logic [LANES-1:0]       en_q;
    logic                   valid_q;
    logic                   ready_q;

    logic [31:0]            word_d;
    logic [LANE_W+6:0]      wr_msb_d;
    logic                   full_d;
    logic                   timeout_d;
    logic [IDLE_W-1:0]      idle_d;

`ifdef AES_LOADER_BSWAP_EN
    assign word_d = {s_data[7:0], s_data[15:8], s_data[23:16], s_data[31:24]};
`else
    assign word_d = s_data;
`endif

    // Write position and close conditions for the word currently offered.
    // MSB of word w in lane L is 128L + 32(3-w) + 31, i.e. {L, ~w, 5'b11111}.
    always_comb begin
        wr_msb_d  = {lane_q, ~word_q, 5'b11111};
        full_d    = (word_q == 2'd3) && (lane_q == LANE_LAST);
        idle_d    = idle_q + {{(IDLE_W-1){1'b0}}, 1'b1};
        // en_q[0] is set by the first accepted word, so it marks a non-empty buffer.
        timeout_d = FLUSH_EN && en_q[0] && (idle_q == IDLE_LAST);
    end

    // Loader FSM: packing, idle flush timer and batch handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            word_q  <= 2'd0;
            lane_q  <= '0;
            idle_q  <= '0;
            batch_q <= '0;
            en_q    <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            case (state_q)
                FILL: begin
                    if (s_valid) begin
                        batch_q[wr_msb_d -: 32] <= word_d;
                        en_q[lane_q]            <= 1'b1;
                        idle_q                  <= '0;
                        if (s_last || full_d) begin
                            state_q <= HOLD;
                            valid_q <= 1'b1;
                            ready_q <= 1'b0;
                        end else if (word_q == 2'd3) begin
                            word_q <= 2'd0;
                            lane_q <= lane_q + {{(LANE_W-1){1'b0}}, 1'b1};
                        end else begin
                            word_q <= word_q + 2'd1;
                        end
                    end else if (timeout_d) begin
                        state_q <= HOLD;
                        valid_q <= 1'b1;
                        ready_q <= 1'b0;
                        idle_q  <= '0;
                    end else if (FLUSH_EN && en_q[0]) begin
                        idle_q <= idle_d;
                    end else begin
                        idle_q <= idle_q;
                    end
                end
                HOLD: begin
                    if (batch_ready) begin
                        state_q <= FILL;
                        word_q  <= 2'd0;
                        lane_q  <= '0;
                        idle_q  <= '0;
                        batch_q <= '0;
                        en_q    <= '0;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                    end else begin
                        state_q <= HOLD;
                    end
                end
                default: begin
                    state_q <= FILL;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign s_ready     = ready_q;
    assign batch_in    = batch_q;
    assign batch_en    = en_q;
    assign batch_valid = valid_q;

endmodule

// File: tb/tb_aes_batch_loader.sv
// Scoreboard bench for aes_batch_loader: a word-level packing model queues expected
// batches as words are accepted; a monitor pops and compares on each batch handshake.
module tb_aes_batch_loader;

    localparam int LANES = 5;
    localparam int FT    = 8;
    localparam int BW    = 128 * LANES;

    typedef logic [BW+LANES-1:0] sb_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [31:0]      s_data = 32'd0;
    logic             s_valid = 1'b0;
    logic             s_last = 1'b0;
    logic             s_ready;
    logic [BW-1:0]    batch_in;
    logic [LANES-1:0] batch_en;
    logic             batch_valid;
    logic             batch_ready = 1'b0;

    sb_t              sb_q[$];
    logic [BW-1:0]    m_data;
    logic [LANES-1:0] m_en;
    int               m_w;
    int               m_l;
    int               n_checks = 0;
    int               n_fail = 0;

    aes_batch_loader #(.LANES(LANES), .FLUSH_TIMEOUT(FT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_last      (s_last),
        .s_ready     (s_ready),
        .batch_in    (batch_in),
        .batch_en    (batch_en),
        .batch_valid (batch_valid),
        .batch_ready (batch_ready)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_data = '0;
        m_en   = '0;
        m_w    = 0;
        m_l    = 0;
    endtask

    task automatic model_push();
        sb_q.push_back({m_en, m_data});
        model_clear();
    endtask

    task automatic model_word(input logic [31:0] d, input bit last);
        logic [31:0] p;
        p = d;
`ifdef AES_LOADER_BSWAP_EN
        p = {d[7:0], d[15:8], d[23:16], d[31:24]};
`endif
        m_data[128*m_l + 96 - 32*m_w +: 32] = p;
        m_en[m_l] = 1'b1;
        m_w++;
        if (m_w == 4) begin
            m_w = 0;
            m_l++;
        end
        if (last || m_l == LANES) model_push();
    endtask

    // Called just after a rising edge; returns just after the edge that accepted the word.
    task automatic send(input logic [31:0] d, input bit last);
        int n;
        n = 0;
        s_data  = d;
        s_valid = 1'b1;
        s_last  = last;
        @(negedge clk);
        while (!s_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("send_ready", BW'(s_ready), BW'(1));
        @(posedge clk);
        #1;
        model_word(d, last);
    endtask

    task automatic stream(input logic [31:0] base, input logic [31:0] step, input int cnt, input bit last_end);
        for (int i = 0; i < cnt; i++) send(base + step * 32'(i), last_end && (i == cnt - 1));
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_valid(input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (!batch_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq("wait_valid", BW'(batch_valid), BW'(1));
    endtask

    // Scoreboard: every batch handshake must match the oldest expected batch.
    always @(negedge clk) begin
        if (rst_n && batch_valid && batch_ready) begin
            sb_t e;
            check_eq("sb_nonempty", BW'(sb_q.size() != 0), BW'(1));
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check_eq("sb_en", BW'(batch_en), BW'(e[BW +: LANES]));
                check_eq("sb_data", batch_in, e[BW-1:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        model_clear();
        batch_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rst_s_ready", BW'(s_ready), BW'(1));
        check_eq("rst_valid", BW'(batch_valid), BW'(0));
        check_eq("rst_en", BW'(batch_en), BW'(0));
        check_eq("rst_data", batch_in, '0);

        // Full batch of 20 ascending words.
        stream(32'h00010203, 32'h04040404, 20, 1'b0);
        wait_valid(10);
        check_eq("full_en", BW'(batch_en), BW'(5'b11111));
`ifdef AES_LOADER_BSWAP_EN
        check_eq("bswap_w0", BW'(batch_in[127:96]), BW'(32'h03020100));
`else
        check_eq("full_lane0", BW'(batch_in[127:0]), BW'(128'h000102030405060708090a0b0c0d0e0f));
`endif
        @(posedge clk);
        #1;
        check_eq("full_release", BW'(batch_valid), BW'(0));

        // s_last on the 6th word closes a partial batch.
        stream(32'h10203040, 32'h01010101, 6, 1'b1);
        wait_valid(10);
        check_eq("last_en", BW'(batch_en), BW'(5'b00011));
        check_eq("last_lane1_lo", BW'(batch_in[191:128]), BW'(64'd0));
        check_eq("last_lanes_hi", BW'(batch_in[BW-1:256]), BW'(0));
        @(posedge clk);
        #1;

        // Idle timeout flushes 3 buffered words after exactly FT idle cycles.
        stream(32'hCAFE0001, 32'h00000011, 3, 1'b0);
        model_push();
        for (int i = 1; i < FT; i++) begin
            @(posedge clk);
            #1;
            check_eq("to_early", BW'(batch_valid), BW'(0));
        end
        @(posedge clk);
        #1;
        check_eq("to_valid", BW'(batch_valid), BW'(1));
        check_eq("to_en", BW'(batch_en), BW'(5'b00001));
        check_eq("to_pad", BW'(batch_in[31:0]), BW'(32'd0));
        @(posedge clk);
        #1;
        seen = 0;
        repeat (100) begin
            @(posedge clk);
            #1;
            if (batch_valid) seen++;
        end
        check_eq("empty_no_flush", BW'(seen), BW'(0));

        // Backpressure: batch frozen while batch_ready is low.
        batch_ready = 1'b0;
        stream(32'h80000000, 32'h00000001, 20, 1'b0);
        wait_valid(10);
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            check_eq("hold_s_ready", BW'(s_ready), BW'(0));
            check_eq("hold_data", batch_in, sb_q[0][BW-1:0]);
            @(posedge clk);
            #1;
        end
        batch_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rel_s_ready", BW'(s_ready), BW'(1));
        check_eq("rel_en", BW'(batch_en), BW'(0));
        check_eq("rel_valid", BW'(batch_valid), BW'(0));

        // Asynchronous reset mid-fill discards the partial batch.
        stream(32'hDEAD0000, 32'h00010001, 9, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_valid", BW'(batch_valid), BW'(0));
        check_eq("arst_en", BW'(batch_en), BW'(0));
        check_eq("arst_data", batch_in, '0);
        model_clear();
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("arst_s_ready", BW'(s_ready), BW'(1));
        stream(32'h5A5A0000, 32'h00000003, 20, 1'b0);
        wait_valid(10);
        @(posedge clk);
        #1;

        // s_last on the batch-filling word: one batch, nothing after it.
        stream(32'h01234567, 32'h11111111, 20, 1'b1);
        wait_valid(10);
        @(posedge clk);
        #1;
        seen = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (batch_valid) seen++;
        end
        check_eq("single_close", BW'(seen), BW'(0));

        check_eq("sb_drained", BW'(sb_q.size()), BW'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
